// File: rtl/uart_sample_loader_if.sv
// Byte-in / sample-RAM-out bundle for uart_sample_loader.
// The DUT side uses the slave modport; the byte source / frame consumer uses master.
interface uart_sample_loader_if #(
  parameter int ADDR_W = 6
);
  logic              i_rx_flag;
  logic [7:0]        i_rx_byte;
  logic              i_frame_ack;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              o_frame_ready;
  logic              o_busy;
  logic              o_err;
  logic [1:0]        o_err_code;

  modport master (
    output i_rx_flag,
    output i_rx_byte,
    output i_frame_ack,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data,
    input  o_frame_ready,
    input  o_busy,
    input  o_err,
    input  o_err_code
  );

  modport slave (
    input  i_rx_flag,
    input  i_rx_byte,
    input  i_frame_ack,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data,
    output o_frame_ready,
    output o_busy,
    output o_err,
    output o_err_code
  );
endinterface

// File: rtl/uart_sample_loader.sv
// Assembles sync-prefixed little-endian 16-bit samples from a UART byte stream
// into a sample RAM, with inter-byte timeout and overrun detection.
module uart_sample_loader #(
  parameter int         N_SAMPLES      = 64,
  parameter int         ADDR_W         = 6,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_sample_loader_if.slave  bus
);

  localparam int                TMO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [1:0]        ERR_TMO    = 2'b01;
  localparam logic [1:0]        ERR_OVR    = 2'b10;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    READY = 2'd3
  } state_t;

  state_t             state_reg,      state_next;
  logic [ADDR_W-1:0]  addr_reg,       addr_next;
  logic [7:0]         low_reg,        low_next;
  logic [TMO_W-1:0]   tmo_reg,        tmo_next;
  logic               wr_en_reg,      wr_en_next;
  logic [ADDR_W-1:0]  wr_addr_reg,    wr_addr_next;
  logic [15:0]        wr_data_reg,    wr_data_next;
  logic               ready_reg,      ready_next;
  logic               busy_reg,       busy_next;
  logic               err_reg,        err_next;
  logic [1:0]         err_code_reg,   err_code_next;

  logic               tmo_hit;

  // A byte arriving on the terminal count wins over the timeout.
  assign tmo_hit = (tmo_reg == TMO_LAST) && !bus.i_rx_flag;

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    low_next      = low_reg;
    tmo_next      = tmo_reg;
    wr_en_next    = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;

    case (state_reg)
      HUNT: begin
        tmo_next = '0;
        if (bus.i_rx_flag && (bus.i_rx_byte == SYNC_BYTE)) begin
          state_next = LO;
          addr_next  = '0;
        end
      end

      LO: begin
        if (bus.i_rx_flag) begin
          low_next   = bus.i_rx_byte;
          tmo_next   = '0;
          state_next = HI;
        end else if (tmo_hit) begin
          state_next    = HUNT;
          addr_next     = '0;
          tmo_next      = '0;
          err_next      = 1'b1;
          err_code_next = ERR_TMO;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      HI: begin
        if (bus.i_rx_flag) begin
          wr_en_next   = 1'b1;
          wr_addr_next = addr_reg;
          wr_data_next = {bus.i_rx_byte, low_reg};
          tmo_next     = '0;
          if (addr_reg == ADDR_LAST) begin
            state_next = READY;
          end else begin
            addr_next  = addr_reg + ADDR_W'(1);
            state_next = LO;
          end
        end else if (tmo_hit) begin
          state_next    = HUNT;
          addr_next     = '0;
          tmo_next      = '0;
          err_next      = 1'b1;
          err_code_next = ERR_TMO;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      READY: begin
        tmo_next = '0;
        // Overrun and ack are independent: the byte is dropped, the ack still counts.
        if (bus.i_rx_flag) begin
          err_next      = 1'b1;
          err_code_next = ERR_OVR;
        end
        if (bus.i_frame_ack) begin
          state_next = HUNT;
        end
      end

      default: begin
        state_next = HUNT;
        addr_next  = '0;
        tmo_next   = '0;
      end
    endcase

    // Status levels are derived from the next state so they line up with state_reg.
    ready_next = (state_next == READY);
    busy_next  = (state_next == LO) || (state_next == HI);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= HUNT;
      addr_reg     <= '0;
      low_reg      <= '0;
      tmo_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 2'b00;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      low_reg      <= low_next;
      tmo_reg      <= tmo_next;
      wr_en_reg    <= wr_en_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
    end
  end

  assign bus.o_wr_en       = wr_en_reg;
  assign bus.o_wr_addr     = wr_addr_reg;
  assign bus.o_wr_data     = wr_data_reg;
  assign bus.o_frame_ready = ready_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_err         = err_reg;
  assign bus.o_err_code    = err_code_reg;

endmodule

// File: tb/tb_uart_sample_loader.sv
// Directed bench for uart_sample_loader: expected RAM writes are queued as bytes
// are sent and matched (cycle, address, data) when o_wr_en is seen.
module tb_uart_sample_loader;

  logic clk = 1'b0;
  logic rst;
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   err_pulses = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];

  uart_sample_loader_if #(.ADDR_W(2)) bus ();

  uart_sample_loader #(
    .N_SAMPLES      (4),
    .ADDR_W         (2),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest pending expectation.
  always @(posedge clk) begin
    wr_t w;
    #1;
    if (bus.o_wr_en === 1'b1) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("write_cycle", w.cyc, cyc);
        check("write_addr", 32'(bus.o_wr_addr), 32'(w.addr));
        check("write_data", 32'(bus.o_wr_data), 32'(w.data));
      end
    end
    if (bus.o_err === 1'b1) err_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; leaves the flag low at the next falling edge.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    bus.i_rx_flag   = 1'b1;
    bus.i_rx_byte   = b;
    bus.i_frame_ack = ack;
    @(negedge clk);
    bus.i_rx_flag   = 1'b0;
    bus.i_frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sample(input logic [7:0] lo, input logic [7:0] hi,
                             input logic [1:0] addr, input int gap);
    wr_t w;
    send_byte(lo, 1'b0);
    idle(gap);
    w.cyc  = cyc + 1;
    w.addr = addr;
    w.data = {hi, lo};
    sb.push_back(w);
    send_byte(hi, 1'b0);
  endtask

  task automatic pulse_ack();
    bus.i_frame_ack = 1'b1;
    @(negedge clk);
    bus.i_frame_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   32'(bus.o_wr_en),       32'd0);
    check({tag, "_wr_addr"}, 32'(bus.o_wr_addr),     32'd0);
    check({tag, "_wr_data"}, 32'(bus.o_wr_data),     32'd0);
    check({tag, "_ready"},   32'(bus.o_frame_ready), 32'd0);
    check({tag, "_busy"},    32'(bus.o_busy),        32'd0);
    check({tag, "_err"},     32'(bus.o_err),         32'd0);
    check({tag, "_code"},    32'(bus.o_err_code),    32'd0);
  endtask

  initial begin
    logic [7:0] lo_b;
    logic [7:0] hi_b;

    bus.i_rx_flag   = 1'b0;
    bus.i_rx_byte   = 8'h00;
    bus.i_frame_ack = 1'b0;
    rst             = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Ack outside READY is ignored.
    pulse_ack();
    check("ack_idle_ready", 32'(bus.o_frame_ready), 32'd0);
    check("ack_idle_busy",  32'(bus.o_busy),        32'd0);

    // Nominal frame.
    send_byte(8'hA5, 1'b0);
    check("nominal_busy", 32'(bus.o_busy), 32'd1);
    send_sample(8'h01, 8'h00, 2'd0, 0);
    send_sample(8'h02, 8'h00, 2'd1, 0);
    send_sample(8'h03, 8'h00, 2'd2, 0);
    send_sample(8'h04, 8'h00, 2'd3, 0);
    check("nominal_ready",     32'(bus.o_frame_ready), 32'd1);
    check("nominal_busy_done", 32'(bus.o_busy),        32'd0);
    check("nominal_sb_empty",  32'(sb.size()),         32'd0);
    idle(3);
    check("nominal_ready_hold", 32'(bus.o_frame_ready), 32'd1);
    check("nominal_addr_hold",  32'(bus.o_wr_addr),     32'd3);
    pulse_ack();
    check("ack_ready_drop", 32'(bus.o_frame_ready), 32'd0);

    // Hunt filter, and sync value used as data inside a frame.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("hunt_busy", 32'(bus.o_busy), 32'd0);
    send_byte(8'hA5, 1'b0);
    send_sample(8'h10, 8'h20, 2'd0, 0);
    send_sample(8'h30, 8'hA5, 2'd1, 0);
    send_sample(8'hA5, 8'h40, 2'd2, 0);
    send_sample(8'h55, 8'h66, 2'd3, 0);
    check("hunt_ready", 32'(bus.o_frame_ready), 32'd1);

    // Overrun with coincident ack.
    send_byte(8'h33, 1'b1);
    check("ovr_err",        32'(bus.o_err),         32'd1);
    check("ovr_code",       32'(bus.o_err_code),    32'd2);
    check("ovr_ready",      32'(bus.o_frame_ready), 32'd0);
    check("ovr_data_hold",  32'(bus.o_wr_data),     32'h6655);
    check("ovr_err_pulses", 32'(err_pulses),        32'd1);
    send_byte(8'h11, 1'b0);
    check("ovr_in_hunt", 32'(bus.o_busy), 32'd0);

    // Timeout: 15 idle cycles is still inside the window, the 16th is not.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    idle(15);
    check("tmo_pre_busy", 32'(bus.o_busy),   32'd1);
    check("tmo_pre_errs", 32'(err_pulses),   32'd1);
    idle(1);
    check("tmo_err",      32'(bus.o_err),      32'd1);
    check("tmo_code",     32'(bus.o_err_code), 32'd1);
    check("tmo_busy",     32'(bus.o_busy),     32'd0);
    idle(1);
    check("tmo_err_once", 32'(bus.o_err),      32'd0);
    check("tmo_code_hold", 32'(bus.o_err_code), 32'd1);

    // Bytes landing exactly on the terminal count are accepted; restart at addr 0.
    send_byte(8'hA5, 1'b0);
    idle(15);
    send_sample(8'h22, 8'h33, 2'd0, 15);
    for (int i = 1; i < 4; i++) begin
      lo_b = 8'($urandom);
      hi_b = 8'($urandom);
      send_sample(lo_b, hi_b, 2'(i), 0);
    end
    check("coinc_errs",  32'(err_pulses),        32'd2);
    check("coinc_ready", 32'(bus.o_frame_ready), 32'd1);
    pulse_ack();

    // Reset mid-frame.
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      lo_b = 8'($urandom);
      hi_b = 8'($urandom);
      send_sample(lo_b, hi_b, 2'(i), 0);
    end
    send_byte(8'h77, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_errs", 32'(err_pulses), 32'd2);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      lo_b = 8'($urandom);
      hi_b = 8'($urandom);
      send_sample(lo_b, hi_b, 2'(i), 0);
    end
    check("midrst_ready", 32'(bus.o_frame_ready), 32'd1);
    pulse_ack();
    check("midrst_ack", 32'(bus.o_frame_ready), 32'd0);

    idle(2);
    check("final_sb_empty", 32'(sb.size()),   32'd0);
    check("final_errs",     32'(err_pulses),  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
